// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read-port integer register file with per-register busy scoreboard
//   clk      - clock, all state updates on the rising edge
//   rst      - asynchronous active-high reset; clears registers, scoreboard and read outputs
//   rd_en    - per-port read enable (NRD bits)
//   rd_addr  - packed read addresses, port i at [i*AW +: AW]
//   rd_data  - packed registered read data, port i at [i*XLEN +: XLEN]
//   rd_busy  - registered busy flag of the register read on each port
//   wr_en, wr_addr, wr_data - writeback; clears the busy bit of the written register
//   iss_en, iss_addr        - issue; marks the destination register busy
//   flush    - clears every busy bit, overriding issue that cycle
//   busy_vec - live scoreboard state, bit n = register n busy
// Macro REGFILE_BYPASS_EN selects write-first reads (wr_data and post-update busy);
// when undefined, reads are read-first (old data and pre-update busy).
module regfile_mp_sb #(
   parameter int XLEN = 32,
   parameter int NREGS = 32,
   parameter int NRD = 2,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD-1:0]      rd_en,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [XLEN-1:0]     wr_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic                flush,
   output logic [NREGS-1:0]    busy_vec
);
   logic [XLEN-1:0]  regs_q [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   assign busy_vec = busy_q;
   // issue is applied after writeback so a same-edge new producer keeps the register busy
   always_comb begin
      busy_d = busy_q;
      if (flush) busy_d = '0;
      else begin
         if (wr_en) busy_d[wr_addr] = 1'b0;
         if (iss_en) busy_d[iss_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NREGS; n++) regs_q[n] <= '0;
         busy_q <= '0;
      end else begin
         if (wr_en && wr_addr != '0) regs_q[wr_addr] <= wr_data;
         busy_q <= busy_d;
      end
   end
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d_d, d_q;
      logic            b_d, b_q;
      assign a = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign d_d = (wr_en && wr_addr == a && a != '0) ? wr_data : regs_q[a];
      assign b_d = busy_d[a];
`else
      assign d_d = regs_q[a];
      assign b_d = busy_q[a];
`endif
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            d_q <= '0;
            b_q <= 1'b0;
         end else if (rd_en[i]) begin
            d_q <= d_d;
            b_q <= b_d;
         end
      end
      assign rd_data[i*XLEN +: XLEN] = d_q;
      assign rd_busy[i] = b_q;
   end
endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Next-generation integer register file for the RV32 core.
- Parametrised data width, register count and read-port count.
- x0 hardwired to zero.
- Synchronous (registered) reads with 1-cycle latency.
- Per-register busy scoreboard for in-flight writes, used by the issue stage to detect RAW hazards.
- Sits between decode/issue (read, issue-mark) and writeback (write, busy-clear).

Parameters:
XLEN, 32, data width of each register in bits.
NREGS, 32, number of architectural registers; power of two, >= 2.
NRD, 2, number of independent read ports; >= 1.
AW (localparam), $clog2(NREGS), address width.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
rd_en  input  NRD  per-port read enable.
rd_addr  input  NRD*AW  packed read addresses; port i at [i*AW +: AW].
rd_data  output  NRD*XLEN  packed registered read data; port i at [i*XLEN +: XLEN].
rd_busy  output  NRD  registered busy flag of the register read on port i.
wr_en  input  1  writeback enable.
wr_addr  input  AW  writeback address.
wr_data  input  XLEN  writeback data.
iss_en  input  1  issue: mark iss_addr busy (pending producer).
iss_addr  input  AW  destination register of the issued instruction.
flush  input  1  clear all busy bits (pipeline flush).
busy_vec  output  NREGS  current scoreboard state, bit n = register n busy.

Behaviour:
- Reset (async, rst high):
  - All registers = 0.
  - rd_data = 0, rd_busy = 0, busy_vec = 0.
  - State is held while rst is high.
  - Reset asserted mid-operation overrides any in-flight write, issue or flush in that cycle.
- Write:
  - On clk edge with wr_en=1 and wr_addr != 0, reg[wr_addr] <= wr_data.
  - Writes to x0 are discarded.
- Read:
  - On clk edge with rd_en[i]=1, rd_data[i] <= value of reg[rd_addr[i]]; rd_busy[i] <= busy[rd_addr[i]].
  - Latency is exactly 1 cycle.
  - rd_en[i]=0 holds the previous rd_data[i] and rd_busy[i].
  - rd_addr[i]=0 always returns 0 with rd_busy=0.
  - All ports are independent; any number of ports may read the same address in the same cycle.
- Scoreboard (busy bits), per register n != 0, evaluated at each edge:
  - Priority 1: flush=1 -> busy[n] <= 0 for all n; iss_en is ignored that cycle.
  - Priority 2: iss_en=1 and iss_addr==n -> busy[n] <= 1. This also applies when wr_en targets the same n: the newly issued producer wins.
  - Priority 3: wr_en=1 and wr_addr==n -> busy[n] <= 0.
  - Otherwise busy[n] holds.
  - busy[0] is constant 0; iss_en to x0 is ignored.
  - wr_en to a non-busy register is legal. It writes data and leaves busy at 0.
- busy_vec is a direct (unregistered) view of the busy flops.
- Read/write collision (same edge, rd_addr[i]==wr_addr!=0, wr_en=1): result depends on the optional feature (below).

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined (write-first):
  - A read colliding with a same-edge write returns wr_data.
  - rd_busy returns the post-update busy value for that edge, i.e. after flush/issue/writeback priority is applied.
- Undefined (read-first):
  - A read colliding with a same-edge write returns the old register value.
  - rd_busy returns the pre-update busy value.
- x0 behaviour is identical in both builds.

Test Plan:
1. Reset, then read all regs on both ports -> rd_data=0 and rd_busy=0 one cycle after rd_en.
2. Write x5=0xDEADBEEF; next cycle read port0 x5, port1 x0 -> after 1 cycle: port0=0xDEADBEEF, port1=0x00000000. Then write x0=0x12345678 and read x0 -> 0.
3. Same edge: wr_en x7=0xA5A5A5A5 (x7 previously 0x1), rd_en port0 x7 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN defined; 0x00000001 without.
4. iss_en x3 -> busy_vec[3]=1. Read x3 -> rd_busy=1. Writeback x3=0x10 -> busy_vec[3]=0. Reread -> rd_busy=0, data 0x10.
5. Same edge: iss_en x9 and wr_en x9 -> busy_vec[9]=1 after the edge. Then flush and iss_en x4 in the same cycle -> busy_vec=0.
6. With x2=0x55 and busy_vec[2]=1, assert rst asynchronously mid-cycle while wr_en x2=0x77 -> x2=0 and busy_vec=0 immediately. After release, a read of x2 returns 0.
